instruction_fetch_unit: RTL and testbench

- Requester side of the instruction memory port: owns the PC, drives the fetch address, captures the returned word and hands {pc, inst} to decode over a valid/ready handshake.
- Instruction memory is word-addressed, reads every cycle with no enable, and returns the word on the posedge after the address is presented (1-cycle latency).
- A 2-entry buffer absorbs decode stalls without re-fetching. Branch/jump redirects flush in-flight work.

---
 rtl/ifu_pkg.sv | 25 ++
 rtl/instruction_fetch_unit_if.sv | 52 +++++
 rtl/ifu_skid_buffer.sv | 83 ++++++++
 rtl/instruction_fetch_unit.sv | 115 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifu_pkg
// Description : Shared constants and types for the instruction fetch unit.
//               Default widths, skid-buffer depth, the halt word and the
//               default {pc, inst} fetch-entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package ifu_pkg;

  localparam int IFU_PC_WIDTH   = 32;
  localparam int IFU_INST_WIDTH = 32;
  localparam int IFU_BUF_DEPTH  = 2;

  // Unused instruction memory is zero-filled, so an all-zero word marks the
  // end of the program image.
  localparam logic [IFU_INST_WIDTH-1:0] HALT_WORD = '0;

  typedef struct packed {
    logic [IFU_PC_WIDTH-1:0]   pc;
    logic [IFU_INST_WIDTH-1:0] inst;
  } fetch_entry_t;

endpackage : ifu_pkg
`default_nettype wire

// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit_if
// Description : Bundles the instruction-memory port, the redirect input and
//               the decode-side valid/ready handshake of the fetch unit.
//   master : fetch unit side (drives imem_pc, if_valid, if_pc, if_inst, halted)
//   slave  : environment side (drives imem_inst, redirect_*, if_ready)
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_unit_if
  import ifu_pkg::*;
#(
  parameter int PC_WIDTH   = IFU_PC_WIDTH,
  parameter int INST_WIDTH = IFU_INST_WIDTH
);

  logic [PC_WIDTH-1:0]   imem_pc;
  logic [INST_WIDTH-1:0] imem_inst;
  logic                  redirect_valid;
  logic [PC_WIDTH-1:0]   redirect_pc;
  logic                  if_valid;
  logic                  if_ready;
  logic [PC_WIDTH-1:0]   if_pc;
  logic [INST_WIDTH-1:0] if_inst;
  logic                  halted;

  modport master (
    output imem_pc,
    input  imem_inst,
    input  redirect_valid,
    input  redirect_pc,
    output if_valid,
    input  if_ready,
    output if_pc,
    output if_inst,
    output halted
  );

  modport slave (
    input  imem_pc,
    output imem_inst,
    output redirect_valid,
    output redirect_pc,
    input  if_valid,
    output if_ready,
    input  if_pc,
    input  if_inst,
    input  halted
  );

endinterface : instruction_fetch_unit_if
`default_nettype wire

// File: rtl/ifu_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : ifu_skid_buffer
// Description : Two-entry FIFO of fetch entries built as a head register plus
//               a tail register. The head is the output; it only changes on a
//               push into an empty/draining buffer or on a pop, so it holds
//               while empty and is stable while stalled.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : drop all entries (priority over push/pop)
//   push/data  : write one entry
//   pop        : consume the head
//   head/valid : head entry and its valid flag
//   count      : number of entries held (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_skid_buffer
  import ifu_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  entry_t     push_data,
  input  logic       pop,
  output entry_t     head,
  output logic       valid,
  output logic [1:0] count
);

  entry_t     r_head;
  entry_t     r_tail;
  logic [1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else if (flush) begin
      r_count <= 2'd0;
    end else begin
      case (r_count)
        2'd0: begin
          if (push) begin
            r_head  <= push_data;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          case ({push, pop})
            2'b10: begin
              r_tail  <= push_data;
              r_count <= 2'd2;
            end
            2'b01:   r_count <= 2'd0;
            2'b11:   r_head  <= push_data;
            default: ;
          endcase
        end
        2'd2: begin
          if (pop) begin
            r_head <= r_tail;
            if (push) r_tail  <= push_data;
            else      r_count <= 2'd1;
          end
        end
        default: r_count <= 2'd0;
      endcase
    end
  end

  assign head  = r_head;
  assign valid = (r_count != 2'd0);
  assign count = r_count;

  // The fetch credit rule must never let a word arrive at a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !flush && (r_count == 2'd2)));

endmodule : ifu_skid_buffer
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Owns the PC, issues word addresses to a 1-cycle-latency
//               instruction memory, captures returned words into a 2-entry
//               skid buffer and presents {pc, inst} to decode via valid/ready.
//               Redirects reload the PC and flush everything in flight.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : instruction_fetch_unit_if.master (imem port, redirect,
//                decode handshake, halted)
// Optional    : `define IFU_HALT_DETECT_EN stops fetching after an all-zero
//               word is captured; otherwise halted is constant 0.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter int                  PC_WIDTH   = IFU_PC_WIDTH,
  parameter int                  INST_WIDTH = IFU_INST_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  instruction_fetch_unit_if.master  bus
);

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] inst;
  } entry_t;

  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_pending_pc;
  logic                r_pending;
  logic                w_halted;
  logic [1:0]          w_count;
  logic [2:0]          w_credit;
  logic                w_pop;
  logic                w_issue;
  logic                w_push;
  logic                w_buf_valid;
  entry_t              w_push_entry;
  entry_t              w_head;

  assign w_pop = w_buf_valid && bus.if_ready;

  // Entries that will occupy the buffer after this edge if nothing new is
  // issued; a new address may only go out if its word is sure to find room.
  assign w_credit = {1'b0, w_count} + {2'b00, r_pending} - {2'b00, w_pop};
  assign w_issue  = !bus.redirect_valid && !w_halted && (w_credit < 3'd2);

  // A word still in flight behind a captured halt word is dropped here.
  assign w_push = r_pending && !bus.redirect_valid && !w_halted;

  assign w_push_entry.pc   = r_pending_pc;
  assign w_push_entry.inst = bus.imem_inst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_pending    <= 1'b0;
      r_pending_pc <= '0;
    end else if (bus.redirect_valid) begin
      r_pc      <= bus.redirect_pc;
      r_pending <= 1'b0;
    end else if (w_issue) begin
      r_pending    <= 1'b1;
      r_pending_pc <= r_pc;
      r_pc         <= r_pc + PC_WIDTH'(1);
    end else begin
      r_pending <= 1'b0;
    end
  end

`ifdef IFU_HALT_DETECT_EN
  logic r_halted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halted <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_halted <= 1'b0;
    end else if (w_push && (bus.imem_inst == INST_WIDTH'(HALT_WORD))) begin
      r_halted <= 1'b1;
    end
  end

  assign w_halted = r_halted;
`else
  assign w_halted = 1'b0;
`endif

  // A pop coinciding with a redirect is not taken; the flush wins.
  ifu_skid_buffer #(
    .entry_t   (entry_t)
  ) u_skid_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.redirect_valid),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop && !bus.redirect_valid),
    .head      (w_head),
    .valid     (w_buf_valid),
    .count     (w_count)
  );

  assign bus.imem_pc  = r_pc;
  assign bus.if_valid = w_buf_valid;
  assign bus.if_pc    = w_head.pc;
  assign bus.if_inst  = w_head.inst;
  assign bus.halted   = w_halted;

endmodule : instruction_fetch_unit
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Self-checking bench for instruction_fetch_unit (PC_WIDTH=8).
//               A 1-cycle-latency memory returns 0x100+addr. A reference
//               model tracks the next PC decode must see (reset value, last
//               redirect target, +1 per accepted word) and checks every
//               accepted word, plus directed latency/stall/redirect/wrap
//               checks and a randomized ready/redirect phase.
//               Define IFU_HALT_DETECT_EN to also run the halt scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

  localparam int PW = 8;
  localparam int IW = 32;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  instruction_fetch_unit_if #(.PC_WIDTH(PW), .INST_WIDTH(IW)) bus ();

  instruction_fetch_unit #(
    .PC_WIDTH   (PW),
    .INST_WIDTH (IW),
    .RESET_PC   (8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory image: 0x100+addr, optionally a zero (halt) word at address 7.
  logic zero7 = 1'b0;

  function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
    if (zero7 && (a == 8'd7)) return '0;
    return 32'h100 + {24'h0, a};
  endfunction

  always @(posedge clk) bus.imem_inst <= mem_word(bus.imem_pc);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state.
  logic [PW-1:0] exp_pc;
  logic          m_halted;
  logic          hold_check;
  logic [PW-1:0] hold_pc;
  logic [IW-1:0] hold_inst;
  logic          saw7;
  logic [PW-1:0] delivered[$];

  // Called at a negedge with inputs for the coming posedge already applied.
  task automatic tick();
    if (hold_check) begin
      chk("stall_valid", bus.if_valid, 1'b1);
      chk("stall_pc",    bus.if_pc,    hold_pc);
      chk("stall_inst",  bus.if_inst,  hold_inst);
    end
    if (m_halted) chk("valid_after_halt", bus.if_valid, 1'b0);
`ifndef IFU_HALT_DETECT_EN
    chk("halted_zero", bus.halted, 1'b0);
`endif
    if (bus.redirect_valid) begin
      exp_pc   = bus.redirect_pc;
      m_halted = 1'b0;
    end else if (bus.if_valid && bus.if_ready) begin
      chk("order_pc",   bus.if_pc,   exp_pc);
      chk("order_inst", bus.if_inst, mem_word(exp_pc));
      delivered.push_back(bus.if_pc);
      if (bus.if_pc == 8'd7) saw7 = 1'b1;
      if (mem_word(exp_pc) == '0) m_halted = 1'b1;
      exp_pc = exp_pc + 8'd1;
    end
    hold_check = bus.if_valid && !bus.if_ready && !bus.redirect_valid;
    hold_pc    = bus.if_pc;
    hold_inst  = bus.if_inst;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic redirect_check(input logic [PW-1:0] tgt, input string tag);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = tgt;
    tick();
    bus.redirect_valid = 1'b0;
    chk({tag, "_empty1"}, bus.if_valid, 1'b0);
    tick();
    chk({tag, "_empty2"}, bus.if_valid, 1'b0);
    tick();
    chk({tag, "_valid"}, bus.if_valid, 1'b1);
    chk({tag, "_pc"},    bus.if_pc,    tgt);
    chk({tag, "_inst"},  bus.if_inst,  mem_word(tgt));
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.if_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    exp_pc             = '0;
    m_halted           = 1'b0;
    hold_check         = 1'b0;
    hold_pc            = '0;
    hold_inst          = '0;
    saw7               = 1'b0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid",   bus.if_valid, 1'b0);
    chk("rst_pc",      bus.if_pc,    8'h00);
    chk("rst_inst",    bus.if_inst,  32'h0);
    chk("rst_halted",  bus.halted,   1'b0);
    chk("rst_imem_pc", bus.imem_pc,  8'h00);

    // Release: first valid follows the 2nd edge.
    rst_n        = 1'b1;
    bus.if_ready = 1'b1;
    tick();
    chk("first_valid_early", bus.if_valid, 1'b0);
    tick();
    chk("first_valid", bus.if_valid, 1'b1);
    chk("first_pc",    bus.if_pc,    8'h00);
    chk("first_inst",  bus.if_inst,  32'h100);

    // Stream until pc 3 at the head, with no gaps.
    for (int i = 0; i < 10 && bus.if_pc != 8'd3; i++) begin
      tick();
      chk("free_valid", bus.if_valid, 1'b1);
    end
    chk("reach_pc3", bus.if_pc, 8'd3);

    // Stall 5 cycles: buffer fills, address stops at 5.
    bus.if_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("stall_imem_pc", bus.imem_pc, 8'd5);
    chk("stall_head",    bus.if_pc,   8'd3);
    bus.if_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("resume_valid", bus.if_valid, 1'b1);
    end

    // Redirect with simultaneous pop and capture.
    redirect_check(8'h40, "redir_pop");
    for (int i = 0; i < 4; i++) tick();

    // Redirect with a full buffer.
    bus.if_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    redirect_check(8'h20, "redir_full");
    bus.if_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Back-to-back redirects: the last one wins.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'h10;
    tick();
    redirect_check(8'h30, "redir_b2b");
    for (int i = 0; i < 3; i++) tick();

    // PC wrap.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'hFE;
    tick();
    bus.redirect_valid = 1'b0;
    delivered.delete();
    for (int i = 0; i < 8; i++) tick();
    chk("wrap_count", (delivered.size() >= 4), 1'b1);
    if (delivered.size() >= 4) begin
      chk("wrap_0", delivered[0], 8'hFE);
      chk("wrap_1", delivered[1], 8'hFF);
      chk("wrap_2", delivered[2], 8'h00);
      chk("wrap_3", delivered[3], 8'h01);
    end

    // Randomized ready and redirects against the model.
    for (int i = 0; i < 400; i++) begin
      bus.if_ready       = ($urandom_range(3) != 0);
      bus.redirect_valid = ($urandom_range(24) == 0);
      bus.redirect_pc    = PW'($urandom);
      tick();
    end
    bus.redirect_valid = 1'b0;
    bus.if_ready       = 1'b1;
    for (int i = 0; i < 4; i++) tick();

`ifdef IFU_HALT_DETECT_EN
    // Halt word at 7: delivered, then fetch stops.
    zero7              = 1'b1;
    saw7               = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'd4;
    tick();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("halt_saw7",    saw7,          1'b1);
    chk("halt_flag",    bus.halted,    1'b1);
    chk("halt_valid",   bus.if_valid,  1'b0);
    chk("halt_imem_pc", bus.imem_pc,   8'd9);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'd0;
    tick();
    chk("halt_cleared", bus.halted, 1'b0);
    bus.redirect_valid = 1'b0;
    tick();
    tick();
    chk("halt_resume_valid", bus.if_valid, 1'b1);
    chk("halt_resume_pc",    bus.if_pc,    8'd0);
    for (int i = 0; i < 4; i++) tick();
    zero7 = 1'b0;
`endif

    // Reset mid-operation takes effect immediately.
    rst_n = 1'b0;
    #1;
    chk("midrst_valid",   bus.if_valid, 1'b0);
    chk("midrst_imem_pc", bus.imem_pc,  8'h00);
    chk("midrst_pc",      bus.if_pc,    8'h00);
    @(negedge clk);
    rst_n      = 1'b1;
    exp_pc     = '0;
    m_halted   = 1'b0;
    hold_check = 1'b0;
    tick();
    tick();
    chk("midrst_first_pc", bus.if_pc, 8'h00);
    for (int i = 0; i < 4; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_instruction_fetch_unit
`default_nettype wire
